instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage feeding the IF/ID pipeline register. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small prefetch FIFO. Presents `instruction_out`/`pc_out`/`valid_out` to IF/ID, and honours hazard-unit stalls and branch/jump redirects from EX.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, fetch address after reset
- `FIFO_DEPTH`, 2, prefetch entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserting (0) clears all state immediately
- `imem_req`  out  1  read request, registered
- `imem_addr`  out  16  word address; stable while `imem_req`=1
- `imem_ack`  in  1  `imem_rdata` valid this cycle; completes request
- `imem_rdata`  in  16  instruction word
- `stall`  in  1  hazard unit: hold current output, no pop
- `redirect`  in  1  taken branch/jump; flush and refetch
- `redirect_pc`  in  16  new fetch address
- `instruction_out`  out  16  FIFO head instruction
- `pc_out`  out  16  FIFO head PC
- `valid_out`  out  1  head valid

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `valid_out`=0, `instruction_out`=16'h0000, `pc_out`=16'h0000, FIFO empty, `fetch_pc`=`RESET_PC`, state IDLE.
- PC is word-addressed: increments by 1, wraps 16'hFFFF→16'h0000 silently.
- Slot reservation: a request issues only when `count` < `FIFO_DEPTH`; the slot is reserved until ack. Overflow is therefore impossible.
- FSM states:
  - IDLE
    - if space, go to WAIT with `imem_req`=1, `imem_addr`=`fetch_pc`.
  - WAIT
    - `imem_ack` without redirect: push {`fetch_pc`, `imem_rdata`} and increment `fetch_pc`.
    - After the push, stay in WAIT at the new address if space remains (counting this cycle's pop); otherwise go to IDLE with `imem_req`=0.
  - DROP
    - `imem_req` stays 1 at the old address. A request is never withdrawn.
    - On `imem_ack`, discard the data and go to WAIT at `fetch_pc`.
- Pop: when `valid_out`=1 and `stall`=0, the head advances at the edge. Push and pop in the same cycle are allowed.
- Outputs: combinational from the FIFO head. When empty, `instruction_out`/`pc_out` hold 16'h0000.
- Redirect has priority over stall, push and pop:
  - FIFO flushed; `fetch_pc` ← `redirect_pc`.
  - In IDLE, or in WAIT with `imem_ack`=1 the same cycle: returning data discarded; next state WAIT at `redirect_pc`.
  - In WAIT with `imem_ack`=0: next state DROP.
  - In DROP: only `fetch_pc` is updated; a later redirect replaces an earlier one.
- `stall` never blocks fetching into free FIFO slots.
- Reset mid-request: state clears immediately. The memory must tolerate an abandoned request (reset is global).

## Timing
- First request: cycle 1 after reset release. With zero-wait memory (ack in the first req cycle), `valid_out`=1 in cycle 2.
- Sustained throughput with ack every cycle and no stall: one instruction per cycle.
- Redirect sampled at edge N, zero-wait memory: `imem_addr`=`redirect_pc` in cycle N+1; `valid_out`=1 with `pc_out`=`redirect_pc` in cycle N+2.
- `valid_out`=0 in the cycle after any redirect.
- Memory wait of k cycles adds k cycles of latency per request.

## Configuration
- `FETCH_PERF_EN` defined:
  - adds output ports `fetched_count` [15:0], which increments per accepted push, and `dropped_count` [15:0], which increments per discarded ack plus each flushed FIFO entry;
  - both reset to 0 and wrap.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg`:
  - constants `PC_W`=16, `INSTR_W`=16;
  - state enum {IDLE, WAIT, DROP};
  - struct `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_buffer`: a synchronous FIFO of `fetch_entry_t`, depth `FIFO_DEPTH`, with push/pop/flush, count, and head outputs. Flush has priority over push.
- FSM, PC and reservation logic live in the top module.

## Test plan
- Reset release, zero-wait memory, `stall`=0, memory returns 16'h1000+addr → `pc_out` 0000,0001,0002 with `instruction_out` 1000,1001,1002 on consecutive cycles from cycle 2.
- Hold `stall`=1 for 5 cycles → `pc_out` held. After 2 pushes, `imem_req` drops to 0 (FIFO full). Release → sequence continues with no gap or duplicate.
- `redirect`=1, `redirect_pc`=16'h0040, memory ack pending with 3-cycle wait → DROP. The old word is discarded; next `valid_out` shows `pc_out`=0040. With `FETCH_PERF_EN`, `dropped_count` increments.
- Redirect coincident with ack and `stall`=1 → acked word not pushed, FIFO empty, `valid_out`=0 next cycle, then `pc_out`=`redirect_pc`.
- `fetch_pc`=16'hFFFF → outputs FFFF then 0000.
- Assert reset mid-WAIT → `imem_req`=0 and `valid_out`=0 immediately (asynchronous). After release, fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
// Optional FETCH_PERF_EN adds fetch/drop counters in the top.
package fetch_pkg;

  localparam int PC_W = 16;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0] PC_ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_inc(
    input logic [PC_W-1:0] pc
  );
    return pc + PC_ONE;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of fetch entries; flush beats push and pop.
// Head reads as zero while empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         head_valid
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    head_valid = (count != '0);
    do_pop     = pop & head_valid;
    do_push    = push & ((count != FULL) | do_pop);
    head       = head_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, imem req/ack FSM, prefetch FIFO to IF/ID.
// Define FETCH_PERF_EN for fetched_count/dropped_count ports.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetched_count,
  output logic [15:0]        dropped_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] addr_nxt;
  logic          req_nxt;
  logic          discard;

  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   occ_next;
  logic          has_space;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  fetch_buffer #(
    .DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_entry(push_entry),
    .count     (count),
    .head      (head),
    .head_valid(valid_out)
  );

  assign instruction_out = head.instr;
  assign pc_out          = head.pc;

  // Space is judged after this cycle's push and pop, so a
  // full FIFO that drains this cycle can refetch without a bubble.
  always_comb begin
    pop        = valid_out & ~stall & ~redirect;
    push       = (state == WAIT) & imem_ack & ~redirect;
    push_entry = '{pc: fetch_pc, instr: imem_rdata};
    occ_next   = {1'b0, count} + (CW+1)'(push)
               - (CW+1)'(pop);
    has_space  = (occ_next < DEPTH_W);
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    addr_nxt  = imem_addr;
    req_nxt   = imem_req;
    discard   = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          state_nxt = WAIT;
          pc_nxt    = redirect_pc;
          addr_nxt  = redirect_pc;
          req_nxt   = 1'b1;
        end else if (has_space) begin
          state_nxt = WAIT;
          addr_nxt  = fetch_pc;
          req_nxt   = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
          if (imem_ack) begin
            discard  = 1'b1;
            addr_nxt = redirect_pc;
          end else begin
            state_nxt = DROP;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc(fetch_pc);
          if (has_space) begin
            addr_nxt = pc_inc(fetch_pc);
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      DROP: begin
        // The stale request stays on the bus until memory acks it.
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        if (imem_ack) begin
          discard   = 1'b1;
          state_nxt = WAIT;
          addr_nxt  = redirect ? redirect_pc : fetch_pc;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= pc_nxt;
      imem_addr <= addr_nxt;
      imem_req  <= req_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] flushed;

  assign flushed = redirect ? 16'(count) : 16'h0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_count <= 16'h0000;
      dropped_count <= 16'h0000;
    end else begin
      fetched_count <= fetched_count + 16'(push);
      dropped_count <= dropped_count + 16'(discard) + flushed;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit.
// Builds with or without FETCH_PERF_EN.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instruction_out;
  logic [15:0] pc_out;
  logic        valid_out;
`ifdef FETCH_PERF_EN
  logic [15:0] fetched_count;
  logic [15:0] dropped_count;
`endif

  instruction_fetch_unit #(
    .RESET_PC  (16'h0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
`ifdef FETCH_PERF_EN
    ,
    .fetched_count  (fetched_count),
    .dropped_count  (dropped_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] gen_pc;
  bit          pending;
  bit          stale;
  bit          last_fired;
  logic [15:0] pend_addr;
  int          wcnt;
  int          w_fix;
  int          occ;
  logic [15:0] m_fetched;
  logic [15:0] m_dropped;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc = gen_pc + 16'd1;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    gen_pc    = 16'h0000;
    pending   = 0;
    stale     = 0;
    occ       = 0;
    m_fetched = 16'h0000;
    m_dropped = 16'h0000;
    top_up();
  endtask

  // rmode: 0 none, 1 always, 2 only while a request waits, 3 only on ack
  task automatic step(input logic s, input int rmode,
                      input logic [15:0] rpc);
    logic ack;
    logic pop;
    logic push;
    @(negedge clk);
    ack  = 1'b0;
    push = 1'b0;
    if (!reset) begin
      imem_ack   = 1'b0;
      stall      = s;
      redirect   = 1'b0;
      last_fired = 0;
      return;
    end
    chk("valid_vs_model", valid_out, occ != 0);
    if (imem_req) begin
      if (!pending) begin
        pending   = 1;
        stale     = 0;
        pend_addr = imem_addr;
        wcnt = (w_fix >= 0) ? w_fix : $urandom_range(0, 3);
      end else begin
        chk("addr_stable", imem_addr, pend_addr);
      end
      if (wcnt == 0) ack = 1'b1;
      else wcnt--;
    end
    last_fired = (rmode == 1) || (rmode == 2 && pending && !ack)
              || (rmode == 3 && ack);
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : 16'($urandom);
    stall       = s;
    redirect    = last_fired;
    redirect_pc = rpc;
    pop = (occ != 0) && !s && !last_fired;
    if (ack) begin
      if (last_fired || stale) m_dropped = m_dropped + 16'd1;
      else begin
        m_fetched = m_fetched + 16'd1;
        push = 1'b1;
      end
      pending = 0;
    end
    if (last_fired) begin
      m_dropped = m_dropped + 16'(occ);
      occ = 0;
      exp_q.delete();
      gen_pc = rpc;
      if (pending) stale = 1;
    end else begin
      occ = occ + int'(push) - int'(pop);
    end
    top_up();
  endtask

  // Monitor: compare the presented head against the expected stream.
  initial begin
    int idle_cyc;
    idle_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        idle_cyc = 0;
      end else begin
        if (valid_out && !redirect) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: output with no expectation");
          end else begin
            chk("sb_pc", pc_out, exp_q[0].pc);
            chk("sb_instr", instruction_out, exp_q[0].instr);
            if (!stall) void'(exp_q.pop_front());
          end
        end
        if (!valid_out) begin
          chk("empty_pc", pc_out, 32'h0);
          chk("empty_instr", instruction_out, 32'h0);
        end
        if (valid_out || redirect) idle_cyc = 0;
        else idle_cyc++;
        if (idle_cyc > 20) begin
          tests++;
          fails++;
          $display("FAIL watchdog: %0d cycles without output",
                   idle_cyc);
          idle_cyc = 0;
        end
      end
    end
  end

  initial begin
    int n;
    w_fix = 0;
    model_clear();
    #12;
    chk("rst_req", imem_req, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", valid_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    step(0, 0, 0);
    chk("first_req", imem_req, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("seq_valid", valid_out, 32'h1);
      chk("seq_pc", pc_out, i);
      chk("seq_instr", instruction_out, 32'h1000 + i);
    end

    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("stall_req_low", imem_req, 32'h0);
    chk("stall_hold_pc", pc_out, 32'h3);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    w_fix = 3;
    n = 0;
    do begin
      step(0, 2, 16'h0040);
      n++;
    end while (!last_fired && n < 20);
    chk("drop_fired", last_fired, 32'h1);
    step(0, 0, 0);
    chk("drop_valid_low", valid_out, 32'h0);
    n = 0;
    while (!valid_out && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    chk("drop_new_pc", pc_out, 32'h0040);

    w_fix = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    n = 0;
    do begin
      step(1, 3, 16'h0100);
      n++;
    end while (!last_fired && n < 10);
    chk("coinc_fired", last_fired, 32'h1);
    step(1, 0, 0);
    chk("coinc_valid_low", valid_out, 32'h0);
    chk("coinc_addr", imem_addr, 32'h0100);
    step(1, 0, 0);
    chk("coinc_valid", valid_out, 32'h1);
    chk("coinc_pc", pc_out, 32'h0100);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    step(0, 1, 16'hFFFF);
    step(0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF);
    step(0, 0, 0);
    chk("wrap_pc_ffff", pc_out, 32'hFFFF);
    step(0, 0, 0);
    chk("wrap_pc_0000", pc_out, 32'h0000);
    chk("wrap_instr", instruction_out, 32'h1000);

    w_fix = 3;
    n = 0;
    do begin
      step(0, 0, 0);
      n++;
    end while (!(pending && wcnt > 0) && n < 20);
    #2;
    reset = 1'b0;
    #1;
    chk("async_req", imem_req, 32'h0);
    chk("async_valid", valid_out, 32'h0);
    model_clear();
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b1;
    w_fix = 0;
    step(0, 0, 0);
    chk("rerun_req", imem_req, 32'h1);
    chk("rerun_addr", imem_addr, 32'h0);
    step(0, 0, 0);
    chk("rerun_pc", pc_out, 32'h0);

    w_fix = -1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 3,
           ($urandom_range(0, 99) < 3) ? 1 : 0,
           16'($urandom));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0);

`ifdef FETCH_PERF_EN
    chk("fetched_count", fetched_count, m_fetched);
    chk("dropped_count", dropped_count, m_dropped);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
